// File: rtl/fir_decim3.sv
// fir_decim3: NR_STAGES-tap FIR filter with decimation by DECIM.
// Samples shift into a delay line. After every DECIM-th accepted sample a
// serial multiply-accumulate (MAC) pass runs over all taps. The rounded and
// saturated result is then presented on data_out for one strobe.
// Bit 0 of data_in, data_out and of each coefficient field is the MSB.
module fir_decim3 #(
    parameter int NR_STAGES = 32,
    parameter int DWIDTH    = 16,
    parameter int DDWIDTH   = 2 * DWIDTH,
    parameter int CWIDTH    = NR_STAGES * DWIDTH,
    parameter int DECIM     = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [0:CWIDTH-1] coeffs,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [0:DWIDTH-1] data_in,
    output logic              out_valid,
    output logic [0:DWIDTH-1] data_out
);

    // Six guard bits cover the sum of up to 64 full-scale products.
    localparam int AWIDTH = DDWIDTH + 6;
    localparam int IWIDTH = (NR_STAGES > 1) ? $clog2(NR_STAGES) : 1;
    localparam int PWIDTH = (DECIM > 1) ? $clog2(DECIM) : 1;

    localparam logic [IWIDTH-1:0] IDX_LAST   = IWIDTH'(NR_STAGES - 1);
    localparam logic [PWIDTH-1:0] PHASE_LAST = PWIDTH'(DECIM - 1);

    // Half an output LSB, plus the output rails, in accumulator scale.
    localparam logic signed [AWIDTH-1:0] RND     = AWIDTH'(1) << (DWIDTH - 2);
    localparam logic signed [AWIDTH-1:0] SAT_MAX = (AWIDTH'(1) << (DWIDTH - 1)) - AWIDTH'(1);
    localparam logic signed [AWIDTH-1:0] SAT_MIN = -(AWIDTH'(1) << (DWIDTH - 1));

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t                    state_q, state_d;
    logic [PWIDTH-1:0]         phase_q, phase_d;
    logic [IWIDTH-1:0]         idx_q, idx_d;
    logic signed [AWIDTH-1:0]  acc_q, acc_d;
    logic signed [DWIDTH-1:0]  delay_q [NR_STAGES];
    logic signed [DWIDTH-1:0]  delay_d [NR_STAGES];
    logic signed [DWIDTH-1:0]  dout_q, dout_d;
    logic                      valid_q, valid_d;
    logic                      ready_q, ready_d;

    logic signed [DWIDTH-1:0]  tap [NR_STAGES];
    logic signed [DWIDTH-1:0]  tap_sel;
    logic signed [DWIDTH-1:0]  smp_sel;
    logic signed [DDWIDTH-1:0] prod;
    logic signed [AWIDTH-1:0]  rnd_sh;
    logic                      accept;

    // Unpack the flat coefficient bus. Each field is MSB-first.
    generate
        for (genvar gi = 0; gi < NR_STAGES; gi++) begin : g_tap
            assign tap[gi] = coeffs[gi*DWIDTH +: DWIDTH];
        end
    endgenerate

    assign tap_sel = tap[idx_q];
    assign smp_sel = delay_q[idx_q];
    assign prod    = DDWIDTH'(tap_sel) * DDWIDTH'(smp_sel);
    assign rnd_sh  = (acc_q + RND) >>> (DWIDTH - 1);
    assign accept  = in_valid && ready_q;

    assign in_ready  = ready_q;
    assign out_valid = valid_q;
    assign data_out  = dout_q;

    // Next-state logic: delay line shift, phase count, MAC sequencing, output rounding.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        dout_d  = dout_q;
        valid_d = 1'b0;
        for (int k = 0; k < NR_STAGES; k++) begin
            delay_d[k] = delay_q[k];
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    delay_d[0] = data_in;
                    for (int k = 1; k < NR_STAGES; k++) begin
                        delay_d[k] = delay_q[k-1];
                    end
                    if (phase_q == PHASE_LAST) begin
                        phase_d = '0;
                        state_d = MAC;
                        idx_d   = '0;
                        acc_d   = '0;
                    end else begin
                        phase_d = phase_q + PWIDTH'(1);
                    end
                end
            end
            MAC: begin
                acc_d = acc_q + AWIDTH'(prod);
                if (idx_q == IDX_LAST) begin
                    idx_d   = '0;
                    state_d = OUT;
                end else begin
                    idx_d = idx_q + IWIDTH'(1);
                end
            end
            OUT: begin
                if (rnd_sh > SAT_MAX) begin
                    dout_d = SAT_MAX[DWIDTH-1:0];
                end else if (rnd_sh < SAT_MIN) begin
                    dout_d = SAT_MIN[DWIDTH-1:0];
                end else begin
                    dout_d = rnd_sh[DWIDTH-1:0];
                end
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // in_ready is registered, so it stays low while rst is held.
        ready_d = (state_d == IDLE);
    end

    // State registers. Reset clears everything, which aborts any pending output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            phase_q <= '0;
            idx_q   <= '0;
            acc_q   <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b0;
            for (int k = 0; k < NR_STAGES; k++) begin
                delay_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
            for (int k = 0; k < NR_STAGES; k++) begin
                delay_q[k] <= delay_d[k];
            end
        end
    end

endmodule

// File: tb/tb_fir_decim3.sv
// Directed testbench for fir_decim3. Expected values are computed by hand or
// with a small rounding formula.
module tb_fir_decim3;

    localparam int NR = 32;
    localparam int DW = 16;
    localparam int CW = NR * DW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [0:CW-1] coeffs = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [0:DW-1] data_in = '0;
    logic          out_valid;
    logic [0:DW-1] data_out;

    logic signed [DW-1:0] dout_s;
    assign dout_s = data_out;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fir_decim3 #(.NR_STAGES(NR), .DWIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .coeffs    (coeffs),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .out_valid (out_valid),
        .data_out  (data_out)
    );

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    task automatic set_tap(input int k, input int v);
        logic signed [DW-1:0] t;
        t = v[DW-1:0];
        coeffs[k*DW +: DW] = t;
    endtask

    // Hold reset for a few cycles, check the reset outputs, then release.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_data_out", dout_s, 0);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_ready", in_ready, 1);
    endtask

    // Present one sample and return the cycle count of its accepting edge.
    // Called and returns on a negedge.
    task automatic send(input int v, output int acc_cyc);
        logic signed [DW-1:0] t;
        t = v[DW-1:0];
        data_in = t;
        in_valid = 1'b1;
        for (int n = 0; n < 100 && !in_ready; n++) @(negedge clk);
        if (!in_ready) check("send_ready", in_ready, 1);
        @(posedge clk);
        #1 acc_cyc = cyc;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Wait, with a bound, for the next out_valid strobe.
    task automatic wait_out(output int d, output int at);
        for (int n = 0; n < 200 && !out_valid; n++) @(negedge clk);
        check("out_seen", out_valid, 1);
        d = dout_s;
        at = cyc;
        @(negedge clk);
    endtask

    function automatic int rnd_tap(input int v);
        longint p;
        p = (longint'(v) * 32767 + 16384) >>> 15;
        return int'(p);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, c3, d, at, v, nov, rdy;
        int acc_q[$];
        int outs[$];

        // Basic path, latency and output hold.
        do_reset();
        coeffs = '0;
        set_tap(0, 16384);
        send(1000, c);
        send(2000, c);
        send(3000, c3);
        check("busy_after_group", in_ready, 0);
        wait_out(d, at);
        check("basic_data", d, 1500);
        check("basic_latency", at - c3, 33);
        repeat (3) @(negedge clk);
        check("hold_valid_low", out_valid, 0);
        check("hold_data", dout_s, 1500);

        // Rounding at the half-LSB point.
        do_reset();
        coeffs = '0;
        set_tap(0, 1);
        send(0, c); send(0, c); send(16384, c);
        wait_out(d, at);
        check("round_up", d, 1);
        send(0, c); send(0, c); send(16383, c);
        wait_out(d, at);
        check("round_down", d, 0);

        // Saturation at both rails.
        do_reset();
        for (int k = 0; k < NR; k++) set_tap(k, 32767);
        for (int i = 0; i < 96; i++) send(32767, c);
        wait_out(d, at);
        check("sat_pos", d, 32767);
        for (int i = 0; i < 96; i++) send(-32768, c);
        wait_out(d, at);
        check("sat_neg", d, -32768);

        // in_valid held high, ramp data, only tap 5 nonzero.
        do_reset();
        coeffs = '0;
        set_tap(5, 32767);
        v = 1;
        data_in = 16'(v);
        in_valid = 1'b1;
        for (int n = 0; n < 150; n++) begin
            rdy = in_ready;
            if (out_valid) outs.push_back(int'(dout_s));
            @(posedge clk);
            #1;
            if (rdy != 0) begin
                acc_q.push_back(cyc);
                v++;
                data_in = 16'(v);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("held_accepts", acc_q.size(), 15);
        if (acc_q.size() >= 7) begin
            check("held_group_span", acc_q[2] - acc_q[0], 2);
            check("held_period_a", acc_q[3] - acc_q[0], 36);
            check("held_period_b", acc_q[6] - acc_q[3], 36);
        end
        check("held_outputs", outs.size(), 4);
        for (int g = 0; g < outs.size() && g < 4; g++) begin
            int x;
            x = (3*g - 2 > 0) ? 3*g - 2 : 0;
            check($sformatf("tap5_out%0d", g), outs[g], rnd_tap(x));
        end

        // Reset in the middle of a MAC pass.
        do_reset();
        coeffs = '0;
        for (int k = 0; k < 6; k++) set_tap(k, 16384);
        send(5000, c); send(6000, c); send(7000, c);
        repeat (10) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        nov = 0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (out_valid) nov++;
        end
        check("abort_no_valid", nov, 0);
        check("abort_data", dout_s, 0);
        send(100, c); send(200, c); send(300, c);
        wait_out(d, at);
        check("post_abort_data", d, 300);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
